eeg_pea_out_col: RTL and testbench

- Downstream stage of the PE array engine; one instance per PE row.
- Collects the PE_COL per-PE output streams of a row (valid/ready, last, data, 8-bit local address) and serialises them by round-robin arbitration onto the row's single output-RAM bank write port.
- Tracks per-PE last flags and signals layer completion to the top-level controller.

---
 rtl/eeg_pea_pkg.sv | 25 ++
 rtl/eeg_pea_out_col_if.sv | 33 +++
 rtl/eeg_pea_rr_arb.sv | 42 ++++
 rtl/eeg_pea_out_col.sv | 106 ++++++++++
 tb/tb_eeg_pea_out_col.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eeg_pea_pkg.sv
// Shared types and helpers for the PE-array output stage: the layer state
// encoding, the default widths and the bank address composition.
package eeg_pea_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_SRC     = 4;
    localparam int DEF_OUT_DW      = 8;
    localparam int DEF_OMUX_ADD_AW = 8;
    localparam int DEF_SRC_AW      = $clog2(DEF_NUM_SRC);
    localparam int DEF_ORAM_ADD_AW = DEF_OMUX_ADD_AW + DEF_SRC_AW;

    // Source index in the upper bits, PE-local address below: pure concatenation.
    function automatic logic [31:0] oram_addr(input logic [31:0] src,
                                              input logic [31:0] loc,
                                              input int unsigned loc_w);
        return (src << loc_w) | loc;
    endfunction

endpackage

// File: rtl/eeg_pea_out_col_if.sv
// Bundle of the per-PE input streams and the output-RAM bank write port.
// A beat moves on a clock edge where valid and ready are both high; valid
// never waits for ready, and a presented beat holds until it is taken.
interface eeg_pea_out_col_if #(
    parameter int NUM_SRC     = 4,
    parameter int OUT_DW      = 8,
    parameter int OMUX_ADD_AW = 8
);
    localparam int SRC_AW      = $clog2(NUM_SRC);
    localparam int ORAM_ADD_AW = OMUX_ADD_AW + SRC_AW;

    logic [NUM_SRC-1:0]                  IN_VLD;
    logic [NUM_SRC-1:0]                  IN_LST;
    logic [NUM_SRC-1:0]                  IN_RDY;
    logic [NUM_SRC-1:0][OUT_DW-1:0]      IN_DAT;
    logic [NUM_SRC-1:0][OMUX_ADD_AW-1:0] IN_ADD;
    logic                                ORAM_WEN;
    logic                                ORAM_RDY;
    logic [ORAM_ADD_AW-1:0]              ORAM_ADD;
    logic [OUT_DW-1:0]                   ORAM_DAT;

    // master: the PE row and the RAM bank around the collector
    modport master (
        output IN_VLD, IN_LST, IN_DAT, IN_ADD, ORAM_RDY,
        input  IN_RDY, ORAM_WEN, ORAM_ADD, ORAM_DAT
    );

    // slave: the collector itself
    modport slave (
        input  IN_VLD, IN_LST, IN_DAT, IN_ADD, ORAM_RDY,
        output IN_RDY, ORAM_WEN, ORAM_ADD, ORAM_DAT
    );
endinterface

// File: rtl/eeg_pea_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// and moves the pointer just past the winner when advance is asserted.
module eeg_pea_rr_arb #(
    parameter  int NUM_SRC = 4,
    localparam int SRC_AW  = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               en,
    input  logic               adv,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SRC_AW-1:0]  idx
);
    logic [SRC_AW-1:0] ptr;
    logic [SRC_AW-1:0] cand;
    logic              found;

    // NUM_SRC is a power of two, so index arithmetic wraps by itself.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = ptr + SRC_AW'(k);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= idx + 1'b1;
        end
    end
endmodule

// File: rtl/eeg_pea_out_col.sv
// Per-row output collector: merges the PE output streams of one row onto the
// bank write port. Optional beat counter: define EEG_PEA_OUT_BEAT_CNT_EN.
module eeg_pea_out_col
    import eeg_pea_pkg::*;
#(
    parameter  int NUM_SRC     = DEF_NUM_SRC,
    parameter  int OUT_DW      = DEF_OUT_DW,
    parameter  int OMUX_ADD_AW = DEF_OMUX_ADD_AW,
    localparam int SRC_AW      = $clog2(NUM_SRC),
    localparam int ORAM_ADD_AW = OMUX_ADD_AW + SRC_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CFG_START,
    input  logic [NUM_SRC-1:0] CFG_SRC_MSK,
    output logic               IS_IDLE,
    output logic               DONE,
    output state_t             dbg_state,
`ifdef EEG_PEA_OUT_BEAT_CNT_EN
    output logic [15:0]        BEAT_CNT,
`endif
    eeg_pea_out_col_if.slave   bus
);
    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] msk_q, lst_seen, elig, gnt;
    logic [SRC_AW-1:0]  gnt_idx;
    logic               run, slot_free, accept, all_done;

    assign elig      = bus.IN_VLD & msk_q & ~lst_seen;
    assign slot_free = ~bus.ORAM_WEN | bus.ORAM_RDY;
    assign accept    = |gnt;
    // Includes the beat accepted this cycle, so the last accept and the
    // move to FLUSH happen on the same edge.
    assign all_done  = &(lst_seen | (gnt & bus.IN_LST) | ~msk_q);
    assign bus.IN_RDY = gnt;
    assign dbg_state  = state;

    eeg_pea_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (elig),
        .en  (run & slot_free),
        .adv (accept),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (CFG_START) state_nxt = ST_RUN;
            ST_RUN:   if (all_done)  state_nxt = ST_FLUSH;
            ST_FLUSH: if (slot_free) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        IS_IDLE = (state == ST_IDLE);
        DONE    = (state == ST_DONE);
        run     = (state == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ORAM_WEN <= 1'b0;
            bus.ORAM_ADD <= '0;
            bus.ORAM_DAT <= '0;
            msk_q        <= '0;
            lst_seen     <= '0;
        end else begin
            if (IS_IDLE && CFG_START) begin
                msk_q    <= CFG_SRC_MSK;
                lst_seen <= '0;
            end else begin
                lst_seen <= lst_seen | (gnt & bus.IN_LST);
            end
            if (accept) begin
                bus.ORAM_WEN <= 1'b1;
                bus.ORAM_ADD <= ORAM_ADD_AW'(oram_addr(32'(gnt_idx),
                                    32'(bus.IN_ADD[gnt_idx]), OMUX_ADD_AW));
                bus.ORAM_DAT <= bus.IN_DAT[gnt_idx];
            end else if (bus.ORAM_RDY) begin
                bus.ORAM_WEN <= 1'b0;
            end
        end
    end

`ifdef EEG_PEA_OUT_BEAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BEAT_CNT <= '0;
        end else if (IS_IDLE && CFG_START) begin
            BEAT_CNT <= '0;
        end else if (accept && BEAT_CNT != 16'hFFFF) begin
            BEAT_CNT <= BEAT_CNT + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_eeg_pea_out_col.sv
// Scoreboard bench for eeg_pea_out_col: directed layers with hand-computed
// bank writes; a negedge monitor pops and compares each accepted write.
module tb_eeg_pea_out_col;
    import eeg_pea_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int EW      = DEF_ORAM_ADD_AW + DEF_OUT_DW;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   cfg_start = 1'b0;
    logic [NUM_SRC-1:0] cfg_src_msk = '0;
    logic   is_idle, done;
    state_t dbg_state;
`ifdef EEG_PEA_OUT_BEAT_CNT_EN
    logic [15:0] beat_cnt;
`endif

    always #5 clk = ~clk;

    eeg_pea_out_col_if #(.NUM_SRC(NUM_SRC), .OUT_DW(8), .OMUX_ADD_AW(8)) bus ();

    eeg_pea_out_col #(.NUM_SRC(NUM_SRC), .OUT_DW(8), .OMUX_ADD_AW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .CFG_START   (cfg_start),
        .CFG_SRC_MSK (cfg_src_msk),
        .IS_IDLE     (is_idle),
        .DONE        (done),
        .dbg_state   (dbg_state),
`ifdef EEG_PEA_OUT_BEAT_CNT_EN
        .BEAT_CNT    (beat_cnt),
`endif
        .bus         (bus)
    );

    // scoreboard and source model
    logic [EW-1:0] exp_q[$];
    logic [16:0]   beats [NUM_SRC][64];
    int            n_beats [NUM_SRC] = '{default: 0};
    int            rd_ptr  [NUM_SRC] = '{default: 0};
    logic          hold    [NUM_SRC] = '{default: 1'b0};
    int            checks = 0, passed = 0;
    int            done_cnt = 0, spurious = 0;
    logic          lat_pend = 1'b0, prev_hold = 1'b0;
    logic [EW-1:0] lat_exp = '0;
    logic [EW:0]   prev_out = '0;
    logic [NUM_SRC-1:0] fire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // driver: presents the head beat of each source just after the edge
    initial begin
        bus.IN_VLD = '0; bus.IN_LST = '0; bus.IN_DAT = '0; bus.IN_ADD = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (rd_ptr[i] < n_beats[i]) begin
                    bus.IN_VLD[i] = 1'b1;
                    bus.IN_LST[i] = beats[i][rd_ptr[i]][16];
                    bus.IN_ADD[i] = beats[i][rd_ptr[i]][15:8];
                    bus.IN_DAT[i] = beats[i][rd_ptr[i]][7:0];
                end else if (hold[i]) begin
                    bus.IN_VLD[i] = 1'b1; bus.IN_LST[i] = 1'b1;
                    bus.IN_ADD[i] = 8'hEE; bus.IN_DAT[i] = 8'hEE;
                end else begin
                    bus.IN_VLD[i] = 1'b0; bus.IN_LST[i] = 1'b0;
                    bus.IN_ADD[i] = 8'h00; bus.IN_DAT[i] = 8'h00;
                end
            end
        end
    end

    // monitor: sampled mid-cycle, when inputs and combinational ready are settled
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) rd_ptr[i] = n_beats[i];
            exp_q.delete();
            lat_pend  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (lat_pend) begin
                check("accept_to_wen", 32'({bus.ORAM_WEN, bus.ORAM_ADD, bus.ORAM_DAT}),
                      32'({1'b1, lat_exp}));
                lat_pend = 1'b0;
            end
            if (prev_hold)
                check("stall_frozen", 32'({bus.ORAM_WEN, bus.ORAM_ADD, bus.ORAM_DAT}),
                      32'(prev_out));
            if (bus.ORAM_WEN && !bus.ORAM_RDY)
                check("stall_in_rdy", 32'(bus.IN_RDY), 32'd0);
            if (bus.ORAM_WEN && bus.ORAM_RDY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL wr_unexpected actual=%h required=none",
                             {bus.ORAM_ADD, bus.ORAM_DAT});
                end else begin
                    check("wr_add_dat", 32'({bus.ORAM_ADD, bus.ORAM_DAT}), 32'(exp_q.pop_front()));
                end
            end
            fire = bus.IN_VLD & bus.IN_RDY;
            if (fire != '0) check("in_rdy_onehot", 32'($countones(fire)), 32'd1);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fire[i]) begin
                    if (rd_ptr[i] < n_beats[i]) begin
                        lat_exp  = {2'(i), beats[i][rd_ptr[i]][15:0]};
                        lat_pend = 1'b1;
                        rd_ptr[i]++;
                    end else begin
                        spurious++;
                    end
                end
            end
            prev_hold = bus.ORAM_WEN && !bus.ORAM_RDY;
            prev_out  = {bus.ORAM_WEN, bus.ORAM_ADD, bus.ORAM_DAT};
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic load(input int s, input logic [7:0] a, input logic [7:0] d, input logic l);
        beats[s][n_beats[s]] = {l, a, d};
        n_beats[s]++;
    endtask

    task automatic expect_wr(input logic [9:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic pulse_start(input logic [3:0] m);
        cfg_src_msk = m; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin tick(); n++; end
        check("done_seen", 32'(done), 32'd1);
    endtask

    // one cycle after DONE: back in IDLE, pulse over, everything written
    task automatic end_layer(input int done_base, input int spur_base);
        tick();
        check("idle_after_done", 32'(is_idle), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt - done_base), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("no_spurious_rdy", 32'(spurious - spur_base), 32'd0);
    endtask

    initial begin
        int db, sb, n;
        bus.ORAM_RDY = 1'b1;
        do_reset();
        // reset state
        check("rst_is_idle", 32'(is_idle), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_outputs", 32'({bus.ORAM_WEN, bus.ORAM_ADD, bus.ORAM_DAT}), 32'd0);
        check("rst_in_rdy", 32'(bus.IN_RDY), 32'd0);

        // single source, three beats
        db = done_cnt; sb = spurious;
        for (int k = 0; k < 3; k++) begin
            load(0, 8'h10 + 8'(k), 8'hA0 + 8'(k), k == 2);
            expect_wr(10'h010 + 10'(k), 8'hA0 + 8'(k));
        end
        pulse_start(4'b0001);
        wait_done();
        end_layer(db, sb);

        // fairness over four sources, with a 5-cycle bank stall mid-stream
        do_reset();
        db = done_cnt; sb = spurious;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NUM_SRC; i++) begin
                load(i, 8'h05, 8'(i * 16 + k), k == 2);
                expect_wr({2'(i), 8'h05}, 8'(i * 16 + k));
            end
        pulse_start(4'hF);
        repeat (4) tick();
        bus.ORAM_RDY = 1'b0;
        repeat (5) tick();
        bus.ORAM_RDY = 1'b1;
        wait_done();
        end_layer(db, sb);

        // masked sources hold VLD and must never be granted; mask change ignored
        do_reset();
        db = done_cnt; sb = spurious;
        hold[0] = 1'b1; hold[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load(1, 8'h20 + 8'(k), 8'h11 + 8'(k), k == 2);
            load(3, 8'h30 + 8'(k), 8'h31 + 8'(k), k == 2);
            expect_wr({2'd1, 8'h20 + 8'(k)}, 8'h11 + 8'(k));
            expect_wr({2'd3, 8'h30 + 8'(k)}, 8'h31 + 8'(k));
        end
        pulse_start(4'b1010);
        cfg_src_msk = 4'hF;
        wait_done();
        end_layer(db, sb);
        hold[0] = 1'b0; hold[2] = 1'b0;

        // empty mask: DONE three cycles after START is raised
        do_reset();
        db = done_cnt; sb = spurious;
        pulse_start(4'b0000);
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        check("msk0_done_latency", 32'(n), 32'd3);
        end_layer(db, sb);

        // START during RUN is ignored (its mask would stall the layer)
        do_reset();
        db = done_cnt; sb = spurious;
        bus.ORAM_RDY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load(0, 8'h40 + 8'(k), 8'h50 + 8'(k), k == 2);
            expect_wr(10'h040 + 10'(k), 8'h50 + 8'(k));
        end
        pulse_start(4'b0001);
        tick();
        pulse_start(4'hF);
        bus.ORAM_RDY = 1'b1;
        wait_done();
        end_layer(db, sb);

        // reset mid-layer with a pending write
        do_reset();
        bus.ORAM_RDY = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int k = 0; k < 4; k++) load(i, 8'(k), 8'h60 + 8'(k), k == 3);
        pulse_start(4'hF);
        repeat (3) tick();
        check("pre_rst_wen", 32'(bus.ORAM_WEN), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        check("midrst_outputs", 32'({bus.ORAM_WEN, bus.ORAM_ADD, bus.ORAM_DAT}), 32'd0);
        check("midrst_idle_rdy", 32'({is_idle, done, bus.IN_RDY}), 32'({1'b1, 1'b0, 4'b0000}));
        tick(); tick();
        rst = 1'b0; bus.ORAM_RDY = 1'b1;
        tick();

        // re-start after reset
        db = done_cnt; sb = spurious;
        load(2, 8'h77, 8'h88, 1'b1);
        expect_wr(10'h277, 8'h88);
        pulse_start(4'b0100);
        wait_done();
        end_layer(db, sb);

`ifdef EEG_PEA_OUT_BEAT_CNT_EN
        // 37 beats: src0 sends 10, the others 9 each
        do_reset();
        db = done_cnt; sb = spurious;
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < NUM_SRC; i++)
                if (i == 0 || k < 9) begin
                    load(i, 8'(k), 8'(i * 16 + k), (i == 0) ? (k == 9) : (k == 8));
                    expect_wr({2'(i), 8'(k)}, 8'(i * 16 + k));
                end
        pulse_start(4'hF);
        wait_done();
        check("beat_cnt_at_done", 32'(beat_cnt), 32'd37);
        end_layer(db, sb);
        check("beat_cnt_held", 32'(beat_cnt), 32'd37);
        db = done_cnt;
        pulse_start(4'b0000);
        check("beat_cnt_cleared", 32'(beat_cnt), 32'd0);
        wait_done();
        tick();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
